// File: rtl/lstm_cell_seq_pkg.sv
// lstm_pkg: shared gate indices, FSM state type and Q-format helpers for the LSTM cell
package lstm_pkg;

    localparam int GATE_F = 0;
    localparam int GATE_I = 1;
    localparam int GATE_C = 2;
    localparam int GATE_O = 3;

    typedef enum logic [2:0] {ACCUM, HREC, ACT, CUPD, HOUT, OUT} state_e;

    localparam int FRACT_WIDTH_DEF = 8;

    function automatic int q_one(input int fw);
        return 1 <<< fw;
    endfunction

    localparam int ONE  = q_one(FRACT_WIDTH_DEF);
    localparam int HALF = ONE >> 1;

endpackage

// File: rtl/lstm_cell_seq_if.sv
// lstm_cell_seq_if: input stream, weights and result handshake of the LSTM cell
interface lstm_cell_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_DIM     = 4
);
    logic [DATA_WIDTH-1:0]          x_data;
    logic                           x_valid;
    logic                           x_ready;
    logic                           x_first;
    logic                           x_last;
    logic [4*IN_DIM*DATA_WIDTH-1:0] wx;
    logic [4*DATA_WIDTH-1:0]        wh;
    logic [4*DATA_WIDTH-1:0]        bias;
    logic [DATA_WIDTH-1:0]          c_out;
    logic [DATA_WIDTH-1:0]          h_out;
    logic                           out_valid;
    logic                           out_ready;
    logic                           busy;

    modport master (
        output x_data, x_valid, x_first, x_last, wx, wh, bias, out_ready,
        input  x_ready, c_out, h_out, out_valid, busy
    );

    modport slave (
        input  x_data, x_valid, x_first, x_last, wx, wh, bias, out_ready,
        output x_ready, c_out, h_out, out_valid, busy
    );

endinterface

// File: rtl/lstm_cell_seq_act.sv
// lstm_act: combinational hard sigmoid (mode 0) or hard tanh (mode 1) in Q format
module lstm_act
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] pre_i,
    input  logic                         mode_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);

    localparam logic signed [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(q_one(FRACT_WIDTH));
    localparam logic signed [DATA_WIDTH:0]   ONE_W  = (DATA_WIDTH+1)'(q_one(FRACT_WIDTH));
    localparam logic signed [DATA_WIDTH:0]   HALF_W = ONE_W >>> 1;

    // pre/4 + 0.5 needs one guard bit so large positive inputs cannot wrap before clamping
    logic signed [DATA_WIDTH:0] s;

    assign s   = ((DATA_WIDTH+1)'(pre_i) >>> 2) + HALF_W;
    assign y_o = mode_i ? (pre_i > ONE_D ? ONE_D : pre_i < -ONE_D ? -ONE_D : pre_i)
                        : (s[DATA_WIDTH] ? '0 : s > ONE_W ? ONE_D : s[DATA_WIDTH-1:0]);

endmodule

// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: sequential single-unit LSTM cell fed one input element per beat
module lstm_cell_seq
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int IN_DIM      = 4,
    parameter int ACC_WIDTH   = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    lstm_cell_seq_if.slave  bus
);

    localparam int IW   = IN_DIM > 1 ? $clog2(IN_DIM) : 1;
    localparam int DW2  = 2 * DATA_WIDTH;
    localparam int WIDE = ACC_WIDTH > DW2 + 1 ? ACC_WIDTH : DW2 + 1;
    localparam logic signed [WIDE-1:0] MAXV = {{(WIDE-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE-1:0] MINV = ~MAXV;

    // clamp a wide signed value into the data word instead of letting it wrap
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [WIDE-1:0] v);
        return v > MAXV ? MAXV[DATA_WIDTH-1:0] : v < MINV ? MINV[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
    endfunction

    state_e                       state_q, state_d;
    logic [IW-1:0]                idx_q;
    logic                         zs_q, run_q;
    logic signed [ACC_WIDTH-1:0]  acc_q [4];
    logic signed [ACC_WIDTH-1:0]  bterm [4];
    logic signed [DATA_WIDTH-1:0] gate_q [4];
    logic signed [DATA_WIDTH-1:0] pre [4];
    logic signed [DATA_WIDTH-1:0] act_y [4];
    logic signed [DW2-1:0]        mx [4];
    logic signed [DW2-1:0]        mh [4];
    logic signed [DATA_WIDTH-1:0] c_q, h_q, hp, cp, tc;
    logic signed [DW2-1:0]        hs;
    logic signed [DW2:0]          cs;
    logic                         beat, last_beat;

    assign beat      = bus.x_valid && bus.x_ready;
    assign last_beat = beat && (bus.x_last || idx_q == IW'(IN_DIM - 1));
    assign hp        = zs_q ? '0 : h_q;
    assign cp        = zs_q ? '0 : c_q;
    assign bus.c_out = c_q;
    assign bus.h_out = h_q;

    for (genvar g = 0; g < 4; g++) begin : g_gate
        assign mx[g]    = DW2'($signed(bus.x_data))
                        * DW2'($signed(bus.wx[(g*IN_DIM + int'(idx_q))*DATA_WIDTH +: DATA_WIDTH]));
        assign mh[g]    = DW2'(hp) * DW2'($signed(bus.wh[g*DATA_WIDTH +: DATA_WIDTH]));
        assign bterm[g] = ACC_WIDTH'($signed(bus.bias[g*DATA_WIDTH +: DATA_WIDTH])) <<< FRACT_WIDTH;
        assign pre[g]   = sat(WIDE'(acc_q[g] >>> FRACT_WIDTH));
        lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)) u_act (
            .pre_i  (pre[g]),
            .mode_i (g == GATE_C),
            .y_o    (act_y[g])
        );
    end

    lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)) u_tanh (
        .pre_i  (c_q),
        .mode_i (1'b1),
        .y_o    (tc)
    );

    assign cs = (DW2+1)'(gate_q[GATE_F]) * (DW2+1)'(cp)
              + (DW2+1)'(gate_q[GATE_I]) * (DW2+1)'(gate_q[GATE_C]);
    assign hs = DW2'(gate_q[GATE_O]) * DW2'(tc);

    // state register; run_q keeps x_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // step sequencing: accumulate, recurrence, activate, cell update, hidden update, present
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   state_d = last_beat ? HREC : ACCUM;
            HREC:    state_d = ACT;
            ACT:     state_d = CUPD;
            CUPD:    state_d = HOUT;
            HOUT:    state_d = OUT;
            OUT:     state_d = bus.out_ready ? ACCUM : OUT;
            default: state_d = ACCUM;
        endcase
    end

    // handshake and status outputs decoded from the current state
    always_comb begin
        bus.x_ready   = run_q && state_q == ACCUM;
        bus.out_valid = state_q == OUT;
        bus.busy      = !(state_q == ACCUM && idx_q == '0);
    end

    // element index, zero-state flag and the four gate accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            zs_q  <= 1'b0;
            for (int g = 0; g < 4; g++) acc_q[g] <= '0;
        end else begin
            if (beat) begin
                idx_q <= last_beat ? '0 : idx_q + IW'(1);
                if (idx_q == '0) zs_q <= bus.x_first;
                for (int g = 0; g < 4; g++) acc_q[g] <= acc_q[g] + ACC_WIDTH'(mx[g]);
            end
            if (state_q == HREC)
                for (int g = 0; g < 4; g++) acc_q[g] <= acc_q[g] + ACC_WIDTH'(mh[g]) + bterm[g];
            if (bus.out_valid && bus.out_ready)
                for (int g = 0; g < 4; g++) acc_q[g] <= '0;
        end
    end

    // registered gate activations and the persistent cell/hidden state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            h_q <= '0;
            for (int g = 0; g < 4; g++) gate_q[g] <= '0;
        end else begin
            if (state_q == ACT)
                for (int g = 0; g < 4; g++) gate_q[g] <= act_y[g];
            if (state_q == CUPD) c_q <= sat(WIDE'(cs >>> FRACT_WIDTH));
            if (state_q == HOUT) h_q <= sat(WIDE'(hs >>> FRACT_WIDTH));
        end
    end

endmodule

// File: tb/tb_lstm_cell_seq.sv
// tb_lstm_cell_seq: directed checks of the LSTM cell with IN_DIM=2 in Q8.8
module tb_lstm_cell_seq;

    localparam int DW = 16;
    localparam int N  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    lstm_cell_seq_if #(.DATA_WIDTH(DW), .IN_DIM(N)) bus ();

    lstm_cell_seq #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .IN_DIM(N), .ACC_WIDTH(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_bias(input logic [15:0] bf, input logic [15:0] bi, input logic [15:0] bc, input logic [15:0] bo);
        bus.bias = {bo, bc, bi, bf};
    endtask

    task automatic step(input logic [15:0] x0, input logic [15:0] x1, input logic first, input int nb);
        logic [15:0] xs [2];
        int          w;
        int          lat;
        xs[0] = x0;
        xs[1] = x1;
        for (int b = 0; b < nb; b++) begin
            w = 0;
            @(negedge clk);
            while (!bus.x_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!bus.x_ready) begin
                chk("x_ready_wait", {31'd0, bus.x_ready}, 32'd1);
                return;
            end
            bus.x_data  = xs[b];
            bus.x_valid = 1'b1;
            bus.x_first = first && b == 0;
            bus.x_last  = b == nb - 1;
            @(posedge clk);
        end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.x_valid = 1'b0;
            bus.x_first = 1'b0;
            bus.x_last  = 1'b0;
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("latency", lat, 4);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.x_data    = '0;
        bus.x_valid   = 1'b0;
        bus.x_first   = 1'b0;
        bus.x_last    = 1'b0;
        bus.out_ready = 1'b0;
        bus.wx        = '0;
        bus.wh        = '0;
        bus.bias      = '0;
        #2;
        chk("rst_c", bus.c_out, 16'h0000);
        chk("rst_h", bus.h_out, 16'h0000);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.x_ready, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.x_ready, 1);

        set_bias(16'h0000, 16'h0000, 16'h0100, 16'h0000);
        step(16'h0100, 16'h0000, 1'b1, 2);
        chk("s1_c", bus.c_out, 16'h0080);
        chk("s1_h", bus.h_out, 16'h0040);
        ack();

        step(16'h0100, 16'h0000, 1'b0, 2);
        chk("s2_c", bus.c_out, 16'h00C0);
        chk("s2_h", bus.h_out, 16'h0060);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_c", bus.c_out, 16'h00C0);
            chk("hold_h", bus.h_out, 16'h0060);
            chk("hold_ready", bus.x_ready, 0);
            chk("hold_busy", bus.busy, 1);
        end
        ack();
        @(negedge clk);
        chk("ack_ready", bus.x_ready, 1);
        chk("ack_valid", bus.out_valid, 0);
        chk("ack_busy", bus.busy, 0);

        step(16'h0100, 16'h0000, 1'b1, 2);
        chk("s5pre_c", bus.c_out, 16'h0080);
        ack();
        bus.wx[15:0]  = 16'h0400;
        bus.wx[31:16] = 16'h7FFF;
        step(16'h0100, 16'h0100, 1'b0, 1);
        chk("s5_c", bus.c_out, 16'h0100);
        chk("s5_h", bus.h_out, 16'h0080);
        ack();
        bus.wx = '0;

        @(negedge clk);
        bus.x_data  = 16'h0100;
        bus.x_valid = 1'b1;
        bus.x_first = 1'b1;
        bus.x_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.x_first = 1'b0;
        chk("s6_busy", bus.busy, 1);
        chk("s6pre_c", bus.c_out, 16'h0100);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_c", bus.c_out, 16'h0000);
        chk("s6_rst_h", bus.h_out, 16'h0000);
        chk("s6_rst_valid", bus.out_valid, 0);
        chk("s6_rst_ready", bus.x_ready, 0);
        bus.x_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(16'h0100, 16'h0000, 1'b1, 2);
        chk("s6_c", bus.c_out, 16'h0080);
        chk("s6_h", bus.h_out, 16'h0040);
        ack();

        set_bias(16'h0800, 16'h0800, 16'h0800, 16'h0800);
        for (int s = 1; s <= 130; s++) begin
            step(16'h0000, 16'h0000, s == 1, 2);
            chk("s3_c", bus.c_out, s * 256 > 32767 ? 32'h7FFF : s * 256);
            chk("s3_h", bus.h_out, 16'h0100);
            ack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
